// File: rtl/lmi_dcache_refill.sv
// Data-cache line refill and tag-write controller: critical-word-first line fill
// into the data RAM, then a tag/valid write; also single-line invalidates.
module lmi_dcache_refill #(
   parameter int TAG_HI     = 31,
   parameter int TAG_LO     = 11,
   parameter int LINE_WORDS = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     miss,
   input  logic [31:0]              miss_addr,
   input  logic                     inval,
   input  logic [31:0]              inval_addr,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     crit_valid,
   output logic [31:0]              crit_data,
   output logic                     bus_req,
   output logic [31:0]              bus_addr,
   input  logic                     bus_gnt,
   input  logic                     bus_rdy,
   input  logic [31:0]              bus_data,
   input  logic                     bus_err,
   output logic                     dram_we,
   output logic [TAG_LO-3:0]        dram_addr,
   output logic [31:0]              dram_wd,
   output logic                     tag_we,
   output logic [TAG_LO-5:0]        tag_idx,
   output logic [TAG_HI-TAG_LO:0]   tag_wd,
   output logic                     val_wd
);

   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int IDX_W  = TAG_LO - 2 - WORD_W;
   localparam int TAG_W  = TAG_HI - TAG_LO + 1;
   localparam logic [WORD_W:0] BEATS = (WORD_W+1)'(LINE_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_FILL, S_TAGWR, S_INVW, S_FIN
   } state_t;

   state_t              state, state_nxt;
   logic [WORD_W-1:0]   wcnt_q;
   logic [WORD_W:0]     nbeat_q;
   logic                err_q;
   logic [29:0]         line_q;
   logic [TAG_W-1:0]    tag_q;
   logic [IDX_W-1:0]    idx_q;

   logic                vld_p1;
   logic                first_p1;
   logic [31:0]         data_p1;
   logic [WORD_W-1:0]   word_p1;

   logic                beat_acc;
   logic                last_wr;
   logic                miss_start;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{miss_addr[1:0], inval_addr[31:TAG_LO], inval_addr[TAG_LO-IDX_W-1:0]};

   // Beats past the fourth (and any beat outside FILL) are dropped.
   assign beat_acc   = (state == S_FILL) && bus_rdy && (nbeat_q != BEATS);
   assign last_wr    = vld_p1 && (nbeat_q == BEATS);
   assign miss_start = (state == S_IDLE) && !inval && miss;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         wcnt_q   <= '0;
         nbeat_q  <= '0;
         err_q    <= 1'b0;
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
      end else begin
         state    <= state_nxt;
         vld_p1   <= beat_acc;
         first_p1 <= beat_acc && (nbeat_q == '0);
         if (miss_start) begin
            wcnt_q  <= miss_addr[2+WORD_W-1:2];
            nbeat_q <= '0;
         end else if (beat_acc) begin
            wcnt_q  <= wcnt_q + WORD_W'(1);
            nbeat_q <= nbeat_q + (WORD_W+1)'(1);
         end
         if (state == S_FIN)
            err_q <= 1'b0;
         else if (beat_acc && bus_err)
            err_q <= 1'b1;
      end
   end

   // Request latch and beat register (stage p1); outputs are qualified by control.
   always_ff @(posedge clk) begin
      if (state == S_IDLE) begin
         if (inval) begin
            idx_q <= inval_addr[TAG_LO-1:2+WORD_W];
         end else if (miss) begin
            idx_q  <= miss_addr[TAG_LO-1:2+WORD_W];
            tag_q  <= miss_addr[TAG_HI:TAG_LO];
            line_q <= miss_addr[31:2];
         end
      end
      if (beat_acc) begin
         data_p1 <= bus_data;
         word_p1 <= wcnt_q;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      bus_req   = 1'b0;
      bus_addr  = '0;
      tag_we    = 1'b0;
      tag_idx   = '0;
      tag_wd    = '0;
      val_wd    = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (inval)
               state_nxt = S_INVW;
            else if (miss)
               state_nxt = S_REQ;
         end
         S_REQ: begin
            bus_req  = 1'b1;
            bus_addr = {line_q, 2'b00};
            if (bus_gnt)
               state_nxt = S_FILL;
         end
         S_FILL: begin
            if (last_wr)
               state_nxt = S_TAGWR;
         end
         S_TAGWR: begin
            tag_we    = 1'b1;
            tag_idx   = idx_q;
            tag_wd    = tag_q;
            val_wd    = ~err_q;
            state_nxt = S_FIN;
         end
         S_INVW: begin
            tag_we    = 1'b1;
            tag_idx   = idx_q;
            state_nxt = S_FIN;
         end
         S_FIN: begin
            done      = 1'b1;
            err       = err_q;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign dram_we    = vld_p1;
   assign dram_addr  = vld_p1 ? {idx_q, word_p1} : '0;
   assign dram_wd    = vld_p1 ? data_p1 : '0;
   assign crit_valid = vld_p1 && first_p1;
   assign crit_data  = (vld_p1 && first_p1) ? data_p1 : '0;

endmodule

// File: doc/lmi_dcache_refill.md
# lmi_dcache_refill

Data-cache line refill and tag-write controller for the LMI. It updates the tag/valid array that the dcache tag comparator reads. On a cacheable load miss it fetches one line from the bus, critical word first, and writes the data RAM word by word. It then writes the new tag with valid set, or clear if the bus reports an error. It also handles single-line invalidates.

## Interface
- TAG_HI, 31, MSB of the stored tag.
- TAG_LO, 11, LSB of the stored tag. Index is [TAG_LO-1:4] and word offset is [3:2].
- LINE_WORDS, 4, words per line. Fixed at 4, so the word counter is 2 bits.
- CLK  in  1  single clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MISS  in  1  level refill request; the requester holds it until DONE.
- MISS_ADDR  in  32  byte address of the missing load; stable while MISS is high.
- INVAL  in  1  one-cycle invalidate request, accepted only when BUSY=0.
- INVAL_ADDR  in  32  address whose line is invalidated.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when a refill or invalidate completes.
- ERR  out  1  valid with DONE; high if the refill took a bus error.
- CRIT_VALID  out  1  one-cycle pulse that forwards the critical word.
- CRIT_DATA  out  32  critical word; valid with CRIT_VALID.
- BUS_REQ  out  1  bus read request.
- BUS_ADDR  out  32  {MISS_ADDR[31:2], 2'b00}, i.e. the critical word address.
- BUS_GNT  in  1  bus grant.
- BUS_RDY  in  1  one data beat valid this cycle.
- BUS_DATA  in  32  beat data.
- BUS_ERR  in  1  beat error; sampled with BUS_RDY.
- DRAM_WE  out  1  data RAM write enable.
- DRAM_ADDR  out  TAG_LO-2  {index, word}.
- DRAM_WD  out  32  data RAM write data.
- TAG_WE  out  1  tag/valid write enable.
- TAG_IDX  out  TAG_LO-4  index to write.
- TAG_WD  out  TAG_HI-TAG_LO+1  tag to write.
- VAL_WD  out  1  valid bit to write.

## Operation
- States: IDLE, REQ, FILL, TAGWR, INVW, FIN.
- IDLE:
  - INVAL=1 goes to INVW. INVAL wins if MISS is also high; MISS stays pending because it is level.
  - Otherwise MISS=1 goes to REQ and latches the line address, tag, index and critical offset.
- REQ: BUS_REQ=1. On BUS_GNT=1 go to FILL and drop BUS_REQ in the next cycle.
- FILL:
  - Beats arrive in wrap order: crit, crit+1, … modulo 4. The 2-bit word counter wraps 3→0.
  - Each BUS_RDY beat is registered and written to the data RAM in the following cycle.
  - The first beat also pulses CRIT_VALID/CRIT_DATA in that following cycle.
  - BUS_ERR on any beat sets a sticky error flag; beats still count and are still written.
  - After the 4th beat go to TAGWR.
- TAGWR: one cycle with TAG_WE=1, TAG_WD=latched tag, VAL_WD=~error. Then go to FIN.
- INVW: one cycle with TAG_WE=1, TAG_IDX=INVAL_ADDR index, TAG_WD=0, VAL_WD=0. Then go to FIN.
- FIN: DONE=1 and ERR=error flag for one cycle. The error flag clears and the FSM returns to IDLE. MISS is not resampled in FIN.
- BUS_RDY outside FILL is ignored.
- Reset mid-operation: the FSM returns to IDLE at once and all outputs drop to 0. A partially filled line is never tag-validated.

## Timing
- Reset values: every output is 0, state=IDLE, counter=0, error=0.
- Cycle 0: MISS sampled high in IDLE.
- Cycle 1: BUS_REQ=1.
- BUS_GNT observed in cycle g: BUS_REQ=0 in g+1, and the state is FILL from g+1.
- Beat in cycle b: DRAM_WE=1 in b+1, with DRAM_ADDR={index, crit+k} for the k-th beat (k=0..3).
- Last beat in cycle b4:
  - b4+1: final DRAM_WE.
  - b4+2: TAG_WE.
  - b4+3: DONE.
- Minimum refill with GNT and four RDY beats back-to-back: DONE 8 cycles after MISS is sampled.
- Invalidate: INVAL in cycle 0, TAG_WE in cycle 1, DONE in cycle 2.
- The RAM write and the tag write never happen in the same cycle.

## Test plan
- Reset with CLK stopped: RESET_N low → all outputs 0 immediately; after release, BUSY=0.
- MISS_ADDR=0x8000_1238 (index 0x23, crit=2), grant at cycle 2, beats 0xA0..0xA3 on consecutive cycles → DRAM_ADDR words 2,3,0,1. Then TAG_WE with TAG_IDX=0x23, TAG_WD=0x100002, VAL_WD=1. CRIT_DATA=0xA0. DONE with ERR=0.
- Same refill, BUS_ERR on beat 3 → all 4 RAM writes occur, VAL_WD=0, ERR=1 with DONE.
- MISS and INVAL (INVAL_ADDR=0x40) high together → invalidate of index 4 first (DONE in cycle 2). The held MISS then starts a refill, with BUS_REQ in cycle 4.
- Gaps between BUS_RDY beats and BUS_RDY pulses while in REQ → stray beats ignored; exactly 4 DRAM_WE pulses and 1 TAG_WE.
- RESET_N asserted after beat 2 → no TAG_WE ever occurs. The next MISS restarts cleanly with counter=crit.
